// File: rtl/stream_mux_pkg.sv
// rtl/stream_mux_pkg.sv - shared types and mode constants for stream_rr_mux
package stream_mux_pkg;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } state_t;

  localparam int MODE_RR    = 0;
  localparam int MODE_FIXED = 1;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational search for the first request at or above ptr, wrapping
module rr_arbiter #(
  parameter  int CHANNELS = 4,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [SEL_W-1:0]    ptr,
  output logic [CHANNELS-1:0] grant,
  output logic [SEL_W-1:0]    idx,
  output logic                any
);

  logic [SEL_W-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int off = 0; off < CHANNELS; off++) begin
      cand = SEL_W'((int'(ptr) + off) % CHANNELS);
      if (!any && req[cand]) begin
        any         = 1'b1;
        idx         = cand;
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_rr_mux.sv
// rtl/stream_rr_mux.sv - N-channel valid/ready stream mux with packet locking and a registered output
module stream_rr_mux
  import stream_mux_pkg::*;
#(
  parameter  int WIDTH    = 4,
  parameter  int CHANNELS = 4,
  parameter  int MODE     = MODE_RR,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      Clk,
  input  logic                      Rst_n,
  input  logic [CHANNELS*WIDTH-1:0] In_Data,
  input  logic [CHANNELS-1:0]       In_Valid,
  input  logic [CHANNELS-1:0]       In_Last,
  output logic [CHANNELS-1:0]       In_Ready,
  input  logic [SEL_W-1:0]          Select,
  output logic [WIDTH-1:0]          Out_Data,
  output logic                      Out_Valid,
  output logic                      Out_Last,
  output logic [SEL_W-1:0]          Out_Chan,
  input  logic                      Out_Ready
);

  state_t               state, state_next;
  logic [SEL_W-1:0]     lock_chan, lock_next;
  logic [SEL_W-1:0]     rr_ptr, ptr_next;
  logic [CHANNELS-1:0]  rr_grant;
  logic [SEL_W-1:0]     rr_idx;
  logic                 rr_any;
  logic [CHANNELS-1:0]  grant_oh;
  logic [SEL_W-1:0]     grant_idx;
  logic                 grant_any;
  logic                 load;
  logic                 xfer;
  logic [WIDTH-1:0]     sel_data;
  logic                 sel_last;

  rr_arbiter #(.CHANNELS(CHANNELS)) u_rr_arbiter (
    .req   (In_Valid),
    .ptr   (rr_ptr),
    .grant (rr_grant),
    .idx   (rr_idx),
    .any   (rr_any)
  );

  assign load = !Out_Valid || Out_Ready;

  // A locked packet owns the output until its last beat, whatever Select or other valids do.
  always_comb begin
    grant_idx = '0;
    grant_any = 1'b0;
    grant_oh  = '0;
    if (state == LOCK) begin
      grant_idx = lock_chan;
      grant_any = In_Valid[lock_chan];
      grant_oh  = grant_any ? (CHANNELS'(1) << lock_chan) : '0;
    end else if (MODE == MODE_FIXED) begin
      grant_idx = Select;
      grant_any = (int'(Select) < CHANNELS) && In_Valid[Select];
      grant_oh  = grant_any ? (CHANNELS'(1) << Select) : '0;
    end else begin
      grant_idx = rr_idx;
      grant_any = rr_any;
      grant_oh  = rr_grant;
    end
  end

  assign In_Ready = (load && Rst_n) ? grant_oh : '0;
  assign xfer     = |In_Ready;

  always_comb begin
    sel_data = '0;
    sel_last = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (grant_oh[i]) begin
        sel_data = In_Data[i*WIDTH +: WIDTH];
        sel_last = In_Last[i];
      end
    end
  end

  always_comb begin
    state_next = state;
    lock_next  = lock_chan;
    ptr_next   = rr_ptr;
    if (xfer) begin
      if (sel_last) begin
        state_next = ARB;
        ptr_next   = (grant_idx == SEL_W'(CHANNELS - 1)) ? '0 : grant_idx + SEL_W'(1);
      end else begin
        state_next = LOCK;
        lock_next  = grant_idx;
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state     <= ARB;
      lock_chan <= '0;
      rr_ptr    <= '0;
    end else begin
      state     <= state_next;
      lock_chan <= lock_next;
      rr_ptr    <= ptr_next;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      Out_Valid <= 1'b0;
      Out_Data  <= '0;
      Out_Last  <= 1'b0;
      Out_Chan  <= '0;
    end else if (xfer) begin
      Out_Valid <= 1'b1;
      Out_Data  <= sel_data;
      Out_Last  <= sel_last;
      Out_Chan  <= grant_idx;
    end else if (Out_Ready) begin
      Out_Valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_rr_mux.sv
// tb/tb_stream_rr_mux.sv - directed bench for stream_rr_mux in round-robin and fixed-select modes
module tb_stream_rr_mux;

  logic        clk = 1'b0;
  logic        rst_n;

  logic [15:0] r_data, f_data;
  logic [3:0]  r_valid, r_last, r_ready, f_valid, f_last, f_ready;
  logic [1:0]  r_sel, f_sel, r_ochan, f_ochan;
  logic [3:0]  r_odata, f_odata;
  logic        r_ovalid, r_olast, r_oready, f_ovalid, f_olast, f_oready;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  stream_rr_mux #(.WIDTH(4), .CHANNELS(4), .MODE(0)) u_rr (
    .Clk(clk), .Rst_n(rst_n), .In_Data(r_data), .In_Valid(r_valid), .In_Last(r_last),
    .In_Ready(r_ready), .Select(r_sel), .Out_Data(r_odata), .Out_Valid(r_ovalid),
    .Out_Last(r_olast), .Out_Chan(r_ochan), .Out_Ready(r_oready)
  );

  stream_rr_mux #(.WIDTH(4), .CHANNELS(4), .MODE(1)) u_fx (
    .Clk(clk), .Rst_n(rst_n), .In_Data(f_data), .In_Valid(f_valid), .In_Last(f_last),
    .In_Ready(f_ready), .Select(f_sel), .Out_Data(f_odata), .Out_Valid(f_ovalid),
    .Out_Last(f_olast), .Out_Chan(f_ochan), .Out_Ready(f_oready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rr_out(input string tag, input logic [3:0] d, input logic [1:0] c, input logic l);
    chk({tag, "_valid"}, r_ovalid, 1'b1);
    chk({tag, "_data"}, r_odata, d);
    chk({tag, "_chan"}, r_ochan, c);
    chk({tag, "_last"}, r_olast, l);
  endtask

  task automatic chk_fx_out(input string tag, input logic [3:0] d, input logic [1:0] c, input logic l);
    chk({tag, "_valid"}, f_ovalid, 1'b1);
    chk({tag, "_data"}, f_odata, d);
    chk({tag, "_chan"}, f_ochan, c);
    chk({tag, "_last"}, f_olast, l);
  endtask

  initial begin
    rst_n    = 1'b0;
    r_data   = 16'hDCBA; r_valid = 4'hF; r_last = 4'hF; r_sel = 2'd0; r_oready = 1'b1;
    f_data   = 16'h0000; f_valid = 4'hF; f_last = 4'hF; f_sel = 2'd2; f_oready = 1'b1;
    #12;
    chk("rst_rr_valid", r_ovalid, 1'b0);
    chk("rst_rr_data", r_odata, 4'h0);
    chk("rst_rr_chan", r_ochan, 2'd0);
    chk("rst_rr_ready", r_ready, 4'h0);
    chk("rst_fx_ready", f_ready, 4'h0);
    chk("rst_fx_valid", f_ovalid, 1'b0);

    // round-robin fairness, single-beat packets
    step();
    rst_n   = 1'b1;
    f_valid = 4'h0;
    #1;
    chk("rr_first_ready", r_ready, 4'b0001);
    step(); chk_rr_out("rr0", 4'hA, 2'd0, 1'b1);
    chk("rr0_ready", r_ready, 4'b0010);
    step(); chk_rr_out("rr1", 4'hB, 2'd1, 1'b1);
    step(); chk_rr_out("rr2", 4'hC, 2'd2, 1'b1);
    step(); chk_rr_out("rr3", 4'hD, 2'd3, 1'b1);
    step(); chk_rr_out("rr4", 4'hA, 2'd0, 1'b1);

    // backpressure for five cycles
    r_oready = 1'b0;
    #1;
    chk("bp_ready0", r_ready, 4'h0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_hold_data", r_odata, 4'hA);
      chk("bp_hold_chan", r_ochan, 2'd0);
      chk("bp_hold_valid", r_ovalid, 1'b1);
      chk("bp_ready", r_ready, 4'h0);
    end
    r_oready = 1'b1;
    #1;
    chk("bp_release_ready", r_ready, 4'b0010);
    step(); chk_rr_out("bp_next", 4'hB, 2'd1, 1'b1);
    r_valid = 4'h0;
    #1;
    chk("idle_ready", r_ready, 4'h0);
    step();
    chk("idle_valid_clear", r_ovalid, 1'b0);

    // packet lock: ch1 3-beat packet while ch2 waits (pointer now 2)
    r_valid = 4'b0010; r_last = 4'b0000; r_data = 16'h0010;
    #1;
    chk("lock_b1_ready", r_ready, 4'b0010);
    step(); chk_rr_out("lock_b1", 4'h1, 2'd1, 1'b0);
    r_valid = 4'b0110; r_last = 4'b0100; r_data = 16'h0720;
    #1;
    chk("lock_b2_ready", r_ready, 4'b0010);
    step(); chk_rr_out("lock_b2", 4'h2, 2'd1, 1'b0);
    r_last = 4'b0110; r_data = 16'h0730;
    #1;
    chk("lock_b3_ready", r_ready, 4'b0010);
    step(); chk_rr_out("lock_b3", 4'h3, 2'd1, 1'b1);
    chk("lock_after_ready", r_ready, 4'b0100);
    step(); chk_rr_out("lock_ch2", 4'h7, 2'd2, 1'b1);

    // wrap: ch3 alone, pointer 3 then 0
    r_valid = 4'b1000; r_last = 4'b1000; r_data = 16'h9000;
    #1;
    chk("wrap_ready_p3", r_ready, 4'b1000);
    step(); chk_rr_out("wrap_ch3_a", 4'h9, 2'd3, 1'b1);
    r_data = 16'h8000;
    #1;
    chk("wrap_ready_p0", r_ready, 4'b1000);
    step(); chk_rr_out("wrap_ch3_b", 4'h8, 2'd3, 1'b1);
    r_valid = 4'hF; r_last = 4'hF; r_data = 16'hDCBA;
    #1;
    chk("wrap_ptr0_ready", r_ready, 4'b0001);
    step(); chk_rr_out("wrap_ch0", 4'hA, 2'd0, 1'b1);

    // reset in the middle of a ch0 packet
    r_valid = 4'b0001; r_last = 4'b0000; r_data = 16'hDCBF;
    step(); chk_rr_out("mid_b1", 4'hF, 2'd0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", r_ovalid, 1'b0);
    chk("mid_rst_data", r_odata, 4'h0);
    chk("mid_rst_chan", r_ochan, 2'd0);
    chk("mid_rst_ready", r_ready, 4'h0);
    r_valid = 4'b0110; r_last = 4'b0110;
    step();
    rst_n = 1'b1;
    #1;
    chk("mid_post_ready", r_ready, 4'b0010);
    r_valid = 4'h0;

    // fixed select: Select moves to 0 mid-packet from ch2
    f_sel = 2'd2; f_valid = 4'b0101; f_last = 4'b0001; f_data = 16'h050E;
    #1;
    chk("fx_b1_ready", f_ready, 4'b0100);
    step(); chk_fx_out("fx_b1", 4'h5, 2'd2, 1'b0);
    f_sel = 2'd0; f_data = 16'h060E; f_last = 4'b0101;
    #1;
    chk("fx_b2_ready", f_ready, 4'b0100);
    step(); chk_fx_out("fx_b2", 4'h6, 2'd2, 1'b1);
    chk("fx_sel0_ready", f_ready, 4'b0001);
    step(); chk_fx_out("fx_ch0", 4'hE, 2'd0, 1'b1);
    f_sel = 2'd1;
    #1;
    chk("fx_sel_invalid_ready", f_ready, 4'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
